// File: rtl/decoder38_pkg.sv
`default_nettype none
// ============================================================================
// decoder38_pkg : shared types and defaults for decoder38_seq
// Revision      : 1.0
// ============================================================================
package decoder38_pkg;

  localparam int unsigned c_DEF_IN_W  = 3;
  localparam int unsigned c_DEF_OUT_W = 1 << c_DEF_IN_W;
  localparam int unsigned c_DEF_HOLD  = 4;
  localparam int unsigned c_DEF_GAP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [c_DEF_OUT_W-1:0] onehot(input logic [c_DEF_IN_W-1:0] code);
    logic [c_DEF_OUT_W-1:0] w_vec;
    w_vec       = '0;
    w_vec[code] = 1'b1;
    return w_vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder38_timer.sv
`default_nettype none
// ============================================================================
// decoder38_timer : loadable down-counter with zero flag, saturating at 0
// Revision        : 1.0
// ============================================================================
module decoder38_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/decoder38_seq.sv
`default_nettype none
// ============================================================================
// decoder38_seq : registered 3-to-8 decoder with HOLD-cycle strobe and GAP
//                 spacing; optional auto-sweep enabled by DECODER38_SCAN_EN
// Revision      : 1.0
// ============================================================================
module decoder38_seq
  import decoder38_pkg::*;
#(
  parameter int unsigned IN_W = c_DEF_IN_W,
  parameter int unsigned HOLD = c_DEF_HOLD,
  parameter int unsigned GAP  = c_DEF_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      code,
  output logic [(1<<IN_W)-1:0] o,
  output logic                 o_valid,
`ifdef DECODER38_SCAN_EN
  input  logic                 scan_start,
  output logic                 scan_done,
`endif
  output logic                 busy
);

  localparam int unsigned c_OUT_W   = 1 << IN_W;
  localparam int unsigned c_MAX_HG  = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned c_CNT_W   = $clog2(c_MAX_HG + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LD = c_CNT_W'(HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  state_t              r_state, w_state_nx;
  logic [c_OUT_W-1:0]  r_o, w_o_nx, w_dec;
  logic                r_o_valid, w_ov_nx;
  logic                w_load, w_dec_en, w_zero, w_finish;
  logic [c_CNT_W-1:0]  w_load_val;
  logic [IN_W-1:0]     w_sel;
  logic                w_scan_start, w_more;

`ifdef DECODER38_SCAN_EN
  logic                r_scan_act, r_scan_done;
  logic [IN_W-1:0]     r_scan_idx;
  logic                w_scan_begin, w_scan_step, w_scan_end;

  assign w_scan_start = scan_start;
  assign w_more       = r_scan_act && (r_scan_idx != '1);
  assign w_sel        = r_scan_act ? (r_scan_idx + IN_W'(1)) : (scan_start ? '0 : code);
  assign scan_done    = r_scan_done;
`else
  assign w_scan_start = 1'b0;
  assign w_more       = 1'b0;
  assign w_sel        = code;
`endif

  generate
    if (IN_W == c_DEF_IN_W) begin : g_pkg_dec
      assign w_dec = onehot(w_sel);
    end else begin : g_shift_dec
      assign w_dec = c_OUT_W'(1) << w_sel;
    end
  endgenerate

  decoder38_timer #(.W(c_CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec_en),
    .zero     (w_zero)
  );

  always_comb begin
    w_state_nx = r_state;
    w_o_nx     = r_o;
    w_ov_nx    = r_o_valid;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec_en   = 1'b0;
    w_finish   = 1'b0;
`ifdef DECODER38_SCAN_EN
    w_scan_begin = 1'b0;
    w_scan_step  = 1'b0;
    w_scan_end   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (en && (in_valid || w_scan_start)) begin
          w_state_nx = ST_HOLD;
          w_o_nx     = w_dec;
          w_ov_nx    = 1'b1;
          w_load     = 1'b1;
          w_load_val = c_HOLD_LD;
`ifdef DECODER38_SCAN_EN
          w_scan_begin = w_scan_start;
`endif
        end
      end
      ST_HOLD, ST_GAP: begin
        if (!en) begin
          // Abort drops the code outright; the counter is cleared for a clean restart
          w_state_nx = ST_IDLE;
          w_o_nx     = '0;
          w_ov_nx    = 1'b0;
          w_load     = 1'b1;
        end else if (!w_zero) begin
          w_dec_en = 1'b1;
        end else if ((r_state == ST_HOLD) && (GAP > 0)) begin
          w_state_nx = ST_GAP;
          w_o_nx     = '0;
          w_ov_nx    = 1'b0;
          w_load     = 1'b1;
          w_load_val = c_GAP_LD;
        end else begin
          w_finish = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_o_nx     = '0;
        w_ov_nx    = 1'b0;
      end
    endcase

    // A sweep chains straight into the next code without passing through IDLE
    if (w_finish) begin
      if (w_more) begin
        w_state_nx = ST_HOLD;
        w_o_nx     = w_dec;
        w_ov_nx    = 1'b1;
        w_load     = 1'b1;
        w_load_val = c_HOLD_LD;
`ifdef DECODER38_SCAN_EN
        w_scan_step = 1'b1;
`endif
      end else begin
        w_state_nx = ST_IDLE;
        w_o_nx     = '0;
        w_ov_nx    = 1'b0;
`ifdef DECODER38_SCAN_EN
        w_scan_end = r_scan_act;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_o       <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_o       <= w_o_nx;
      r_o_valid <= w_ov_nx;
    end
  end

`ifdef DECODER38_SCAN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_act  <= 1'b0;
      r_scan_idx  <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      if (!en) begin
        r_scan_act <= 1'b0;
      end else if (w_scan_begin) begin
        r_scan_act <= 1'b1;
        r_scan_idx <= '0;
      end else if (w_scan_step) begin
        r_scan_idx <= r_scan_idx + IN_W'(1);
      end else if (w_scan_end) begin
        r_scan_act  <= 1'b0;
        r_scan_done <= 1'b1;
      end
    end
  end
`endif

  assign in_ready = en && (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign o        = r_o;
  assign o_valid  = r_o_valid;

endmodule
`default_nettype wire

// File: tb/tb_decoder38_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_decoder38_seq : randomized scoreboard bench for decoder38_seq
// Revision         : 1.0
// ============================================================================
module tb_decoder38_seq;

  localparam int H = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] code = 3'd0;
  logic       in_ready, o_valid, busy;
  logic [7:0] o;
`ifdef DECODER38_SCAN_EN
  logic       scan_start = 1'b0;
  logic       scan_done;
`endif

  always #5 clk = ~clk;

  decoder38_seq #(.IN_W(3), .HOLD(H), .GAP(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code       (code),
    .o          (o),
    .o_valid    (o_valid),
`ifdef DECODER38_SCAN_EN
    .scan_start (scan_start),
    .scan_done  (scan_done),
`endif
    .busy       (busy)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   m_free = 0;
  int   m_accepts = 0;
  int   m_done_cyc = -1;
  int   checks = 0;
  int   failures = 0;
  logic       exp_v;
  logic [7:0] exp_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a code accepted in cycle c owns cycles c+1..c+HOLD+GAP
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || (!en && (cyc < m_free))) begin
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc + 1) exp_q.pop_back();
      m_free     <= cyc + 1;
      m_done_cyc <= -1;
    end else if (en && (cyc >= m_free)) begin
`ifdef DECODER38_SCAN_EN
      if (scan_start) begin
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < H; k++)
            exp_q.push_back('{cyc + 1 + i * (H + G) + k, 8'(1) << i});
        m_free     <= cyc + 1 + 8 * (H + G);
        m_done_cyc <= cyc + 1 + 8 * (H + G);
        m_accepts  <= m_accepts + 1;
      end else
`endif
      if (in_valid) begin
        for (int k = 0; k < H; k++)
          exp_q.push_back('{cyc + 1 + k, 8'(1) << code});
        m_free    <= cyc + 1 + H + G;
        m_accepts <= m_accepts + 1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      exp_o = exp_v ? exp_q[0].val : 8'h00;
      if (exp_v) void'(exp_q.pop_front());
      chk("o_valid", 32'(o_valid), 32'(exp_v));
      chk("o", 32'(o), 32'(exp_o));
      chk("in_ready", 32'(in_ready), 32'(en && (cyc >= m_free)));
      chk("busy", 32'(busy), 32'(cyc < m_free));
`ifdef DECODER38_SCAN_EN
      chk("scan_done", 32'(scan_done), 32'(cyc == m_done_cyc));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c);
    int start;
    int n;
    start    = m_accepts;
    n        = 0;
    in_valid = 1'b1;
    code     = c;
    while (m_accepts == start && n < 40) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    if (m_accepts == start) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout code=%0d actual=no_accept expected=accept", c);
    end
  endtask

  initial begin
    // Reset with a pending code and enable low
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b1; code = 3'd5;
    repeat (3) step();
    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0;
    step();

    issue(3'd3);
    repeat (8) step();

    for (int i = 0; i < 8; i++) issue(3'(i));
    repeat (8) step();

    // Abort two cycles into HOLD, then recover
    issue(3'd6);
    step(); step();
    en = 1'b0;
    step();
    en = 1'b1;
    issue(3'd1);
    repeat (8) step();

    // Reset in the middle of a strobe
    issue(3'd7);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef DECODER38_SCAN_EN
    scan_start = 1'b1; in_valid = 1'b1; code = 3'd2;
    step();
    scan_start = 1'b0; in_valid = 1'b0;
    repeat (8 * (H + G) + 4) step();
`endif

    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 1) != 0);
      code     = 3'($urandom);
`ifdef DECODER38_SCAN_EN
      scan_start = ($urandom_range(0, 39) == 0);
`endif
      step();
    end

    rst_n = 1'b1; en = 1'b1; in_valid = 1'b0;
`ifdef DECODER38_SCAN_EN
    scan_start = 1'b0;
`endif
    repeat (8 * (H + G) + 8) step();
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
